// File: rtl/mul_sequencer.sv
// mul_sequencer: multi-cycle RV64M multiplier controller (MUL/MULH/MULHSU/MULHU).
// A single 64-bit adder is time-shared between operand sign correction,
// 64 shift-add iterations and the final 128-bit two's-complement fix-up.
// Fixed latency: one operation in flight, done_out pulses once per accept.

// Plain 64-bit ripple/carry adder; the only arithmetic resource of the sequencer.
module full_adder_64b (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);
    // Full 65-bit sum, top bit is the carry out.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {64'b0, cin};
endmodule

// Handshake: start_in is sampled only while idle (busy_out low); an accepted
// request raises busy_out from the next cycle until the single-cycle done_out
// pulse, during which result_out is valid. start_in while busy is ignored.
module mul_sequencer #(
    parameter int XLEN       = 64,
    parameter int ITERATIONS = 64
) (
    input  logic            clk_in,
    input  logic            reset_n_in,
    input  logic            start_in,
    input  logic [1:0]      op_in,
    input  logic [XLEN-1:0] operand1_in,
    input  logic [XLEN-1:0] operand2_in,
    output logic            busy_out,
    output logic            done_out,
    output logic [XLEN-1:0] result_out,
    output logic [2:0]      state_out
);
    localparam int CNT_W = $clog2(ITERATIONS + 1);

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PREP_A = 3'd1,
        S_PREP_B = 3'd2,
        S_MUL    = 3'd3,
        S_FIX_LO = 3'd4,
        S_FIX_HI = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t            state;
    logic [1:0]        op_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   mcand;
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;
    logic              neg_a;
    logic              neg_b;
    logic              neg_p;
    logic              fix_carry;
    logic [CNT_W-1:0]  count;

    logic [XLEN-1:0]   add_a;
    logic [XLEN-1:0]   add_b;
    logic              add_cin;
    logic [XLEN-1:0]   add_sum;
    logic              add_cout;

    logic              signed1;
    logic              signed2;

    assign state_out = state;

    // rs1 is signed for MULH/MULHSU, rs2 only for MULH.
    assign signed1 = (op_in == OP_MULH) || (op_in == OP_MULHSU);
    assign signed2 = (op_in == OP_MULH);

    full_adder_64b u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Adder input steering: each state borrows the adder for its own job.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        case (state)
            S_PREP_A: begin
                add_a   = neg_a ? ~a_q : a_q;
                add_cin = neg_a;
            end
            S_PREP_B: begin
                add_a   = neg_b ? ~b_q : b_q;
                add_cin = neg_b;
            end
            S_MUL: begin
                add_a = hi;
                add_b = lo[0] ? mcand : '0;
            end
            S_FIX_LO: begin
                add_a   = neg_p ? ~lo : lo;
                add_cin = neg_p;
            end
            S_FIX_HI: begin
                add_a   = neg_p ? ~hi : hi;
                add_cin = fix_carry;
            end
            default: begin
                add_a   = '0;
                add_b   = '0;
                add_cin = 1'b0;
            end
        endcase
    end

    // Sequencer FSM with registered busy/done/result outputs.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state      <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            mcand      <= '0;
            hi         <= '0;
            lo         <= '0;
            neg_a      <= 1'b0;
            neg_b      <= 1'b0;
            neg_p      <= 1'b0;
            fix_carry  <= 1'b0;
            count      <= '0;
            busy_out   <= 1'b0;
            done_out   <= 1'b0;
            result_out <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_out <= 1'b0;
                    if (start_in) begin
                        op_q     <= op_in;
                        a_q      <= operand1_in;
                        b_q      <= operand2_in;
                        neg_a    <= signed1 & operand1_in[XLEN-1];
                        neg_b    <= signed2 & operand2_in[XLEN-1];
                        neg_p    <= (signed1 & operand1_in[XLEN-1]) ^
                                    (signed2 & operand2_in[XLEN-1]);
                        busy_out <= 1'b1;
                        state    <= S_PREP_A;
                    end
                end
                S_PREP_A: begin
                    // Magnitude of rs1; INT64_MIN wraps to itself, which is the
                    // correct unsigned magnitude.
                    mcand <= add_sum;
                    state <= S_PREP_B;
                end
                S_PREP_B: begin
                    lo    <= add_sum;
                    hi    <= '0;
                    count <= '0;
                    state <= S_MUL;
                end
                S_MUL: begin
                    hi    <= {add_cout, add_sum[XLEN-1:1]};
                    lo    <= {add_sum[0], lo[XLEN-1:1]};
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(ITERATIONS - 1)) begin
                        state <= S_FIX_LO;
                    end
                end
                S_FIX_LO: begin
                    // Carry into the high half only when the low half was zero.
                    lo        <= add_sum;
                    fix_carry <= add_cout;
                    state     <= S_FIX_HI;
                end
                S_FIX_HI: begin
                    // Result is registered here so it is valid alongside done_out.
                    hi         <= add_sum;
                    result_out <= (op_q == OP_MUL) ? lo : add_sum;
                    done_out   <= 1'b1;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    done_out <= 1'b0;
                    busy_out <= 1'b0;
                    state    <= S_IDLE;
                end
                default: begin
                    done_out <= 1'b0;
                    busy_out <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed vector table, multi-cycle
// corner sequences (ignored starts, back-to-back, mid-operation reset) and
// randomized operations against a 128-bit arithmetic reference model.
module tb_mul_sequencer;
    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [63:0] operand1;
    logic [63:0] operand2;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic [2:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;
    logic [63:0] exp_q[$];

    localparam int LATENCY = 69;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    mul_sequencer dut (
        .clk_in      (clk),
        .reset_n_in  (reset_n),
        .start_in    (start),
        .op_in       (op),
        .operand1_in (operand1),
        .operand2_in (operand2),
        .busy_out    (busy),
        .done_out    (done),
        .result_out  (result),
        .state_out   (state_dbg)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: sign/zero-extend both operands to 128 bits and multiply.
    function automatic logic [63:0] ref_mul(input logic [1:0] f, input logic [63:0] a,
                                            input logic [63:0] b);
        logic [127:0] ea;
        logic [127:0] eb;
        logic [127:0] p;
        ea = (f == 2'b01 || f == 2'b10) ? {{64{a[63]}}, a} : {64'b0, a};
        eb = (f == 2'b01) ? {{64{b[63]}}, b} : {64'b0, b};
        p  = ea * eb;
        return (f == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Driver: present a request for one cycle and queue its expected result.
    task automatic start_op(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] exp);
        @(negedge clk);
        start    = 1'b1;
        op       = f;
        operand1 = a;
        operand2 = b;
        @(posedge clk);
        #1;
        accept_cyc = cyc;
        start = 1'b0;
        exp_q.push_back(exp);
        check("busy_after_accept", {63'b0, busy}, 64'd1);
    endtask

    // Wait (bounded) for done, then check latency and result from the queue.
    task automatic finish_op(input string tag);
        int n;
        logic [63:0] e;
        n = 0;
        while (!done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: done not seen within 200 cycles", tag);
        end else begin
            check({tag, "_latency"}, 64'(cyc - accept_cyc + 1), 64'(LATENCY));
            check({tag, "_result"}, result, e);
        end
    endtask

    task automatic run_op(input logic [1:0] f, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp, input string tag);
        start_op(f, a, b, exp);
        finish_op(tag);
        @(posedge clk);
        #1;
        check({tag, "_busy_after"}, {63'b0, busy}, 64'd0);
        check({tag, "_done_pulse"}, {63'b0, done}, 64'd0);
        check({tag, "_result_held"}, result, exp);
    endtask

    function automatic logic [63:0] rnd_operand();
        logic [63:0] v;
        case ($urandom_range(0, 7))
            0: v = 64'h0;
            1: v = 64'hFFFF_FFFF_FFFF_FFFF;
            2: v = 64'h8000_0000_0000_0000;
            3: v = 64'h7FFF_FFFF_FFFF_FFFF;
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        int dn;
        logic [1:0]  rf;
        logic [63:0] ra;
        logic [63:0] rb;

        // Directed table: hand-computed products.
        vecs.push_back('{2'b00, 64'd3, 64'd5, 64'h0000_0000_0000_000F});
        vecs.push_back('{2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE});
        vecs.push_back('{2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001});
        vecs.push_back('{2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000});
        vecs.push_back('{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000});
        vecs.push_back('{2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF});
        vecs.push_back('{2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h0000_0000_0000_0001});
        vecs.push_back('{2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000});
        vecs.push_back('{2'b00, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000});
        vecs.push_back('{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF});

        // Reset block.
        reset_n  = 1'b0;
        start    = 1'b0;
        op       = 2'b00;
        operand1 = '0;
        operand2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_result", result, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed vectors.
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // start pulses during MUL and during DONE are ignored.
        start_op(2'b00, 64'd3, 64'd5, 64'h0000_0000_0000_000F);
        repeat (20) @(posedge clk);
        #1;
        start    = 1'b1;
        op       = 2'b11;
        operand1 = 64'hFFFF_FFFF_FFFF_FFFF;
        operand2 = 64'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        finish_op("ignore_mid");
        start    = 1'b1;
        op       = 2'b01;
        operand1 = 64'h1234;
        operand2 = 64'h5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ignore_done_busy", {63'b0, busy}, 64'd0);
        check("ignore_done_result", result, 64'h0000_0000_0000_000F);
        // Accepted in the first idle cycle after DONE.
        run_op(2'b00, 64'd11, 64'd13, 64'd143, "back_to_back");

        // Reset during MUL at cycle 30.
        start_op(2'b00, 64'd9, 64'd9, 64'd81);
        repeat (29) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_done", {63'b0, done}, 64'd0);
        check("abort_result", result, 64'd0);
        void'(exp_q.pop_back());
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        dn = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        check("abort_no_done", 64'(dn), 64'd0);
        check("abort_idle_busy", {63'b0, busy}, 64'd0);
        run_op(2'b00, 64'd7, 64'd6, 64'h0000_0000_0000_002A, "after_abort");

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            rf = 2'($urandom_range(0, 3));
            ra = rnd_operand();
            rb = rnd_operand();
            run_op(rf, ra, rb, ref_mul(rf, ra, rb), $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
- Multi-cycle RV64M multiplier controller (MUL/MULH/MULHSU/MULHU).
- Time-shares one FullAdder64b instance for three jobs: operand sign correction, 64 shift-add iterations, and 128-bit result negation.
- Sits beside the ALU in the execute stage; the pipeline issues start and waits for done.
- Fixed latency, one operation in flight.

Parameters:
- XLEN, 64, operand/result width; only 64 is supported (matches the shared adder).
- ITERATIONS, 64, number of shift-add steps; must equal XLEN.

Ports:
- clk_in  input  1  clock, rising edge
- reset_n_in  input  1  asynchronous active-low reset
- start_in  input  1  request a multiply; accepted only in IDLE
- op_in  input  2  00=MUL, 01=MULH, 10=MULHSU, 11=MULHU; sampled on accept
- operand1_in  input  64  rs1 value; sampled on accept
- operand2_in  input  64  rs2 value; sampled on accept
- busy_out  output  1  high in every state except IDLE
- done_out  output  1  single-cycle pulse; result_out is valid
- result_out  output  64  MUL: low 64 product bits; others: high 64 bits. Held until the next accept.

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy_out=0, done_out=0, result_out=0, all internal registers 0.
- Signedness: rs1 is signed for MULH/MULHSU; rs2 is signed for MULH only. MUL and MULHU are treated as unsigned.
- Sign latch on accept: neg_a = signed1 & rs1[63]; neg_b = signed2 & rs2[63]; neg_p = neg_a ^ neg_b.
- Adder input mux by state, the only user of the adder:
  - PREP_A: (~a or a, 0, cin=neg_a)
  - PREP_B: (~b or b, 0, cin=neg_b)
  - MUL: (hi, lo[0] ? mcand : 0, 0)
  - FIX_LO: (~lo or lo, 0, neg_p)
  - FIX_HI: (~hi or hi, 0, fix_carry)
- FSM, one state per cycle except MUL:
  - IDLE: on start_in, latch op and operands, go to PREP_A. Otherwise stay.
  - PREP_A: mcand <= |rs1| (or rs1 unchanged).
  - PREP_B: lo <= |rs2| (or unchanged); hi <= 0; iteration count <= 0.
  - MUL: sum, c = hi + (lo[0] ? mcand : 0); {hi,lo} <= {c, sum, lo} >> 1. Count increments. Exit after the ITERATIONS-th step.
  - FIX_LO: lo <= adder sum; fix_carry <= carry_out (carry is 0 when neg_p=0).
  - FIX_HI: hi <= adder sum.
  - DONE: result_out <= (op==MUL) ? lo : hi; done_out=1 for this cycle only. Next state IDLE.
- Latency: accept edge at cycle 0 → done_out high during cycle 69 (2+64+2+1 states). Independent of data and op.
- |INT64_MIN| = 0x8000_0000_0000_0000, valid as an unsigned magnitude; no special case.
- start_in outside IDLE is ignored with no side effects, including in the DONE cycle. Earliest back-to-back accept is the cycle after DONE.
- Reset during any state aborts immediately: done_out is not pulsed and result_out returns to 0.
- Adder carry_out is discarded in PREP states; the wrap on INT64_MIN is intended.

Test Plan:
- Reset, then MUL 3×5: done_out pulses exactly 69 cycles after accept with result_out=0x000000000000000F; busy_out low the following cycle.
- MULHU 0xFFFFFFFFFFFFFFFF × 0xFFFFFFFFFFFFFFFF → 0xFFFFFFFFFFFFFFFE. Then MUL with the same operands → 0x0000000000000001.
- MULH 0x8000000000000000 × 0x8000000000000000 → 0x4000000000000000. MULH −1×−1 → 0x0000000000000000.
- MULHSU rs1=0xFFFFFFFFFFFFFFFF (−1), rs2=2 → 0xFFFFFFFFFFFFFFFF. MULHU with the same operands → 0x0000000000000001.
- Pulse start_in with different operands during MUL and during DONE: no effect, result matches the first request. Start accepted on the cycle after DONE completes correctly.
- Assert reset_n_in mid-MUL (cycle 30): busy_out, done_out and result_out go to 0 immediately and no done pulse follows. A new MUL 7×6 after release → 0x000000000000002A.
